// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_pkg
//  Description : Shared defaults and width helper for the debounce bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

   localparam int c_def_sync   = 2;
   localparam int c_def_stable = 255;
   localparam int c_def_hold   = 0;

   // Bits needed to hold values 0..value-1 (matches $clog2 semantics).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            r = i + 1;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_ch
//  Description : One debounce channel: synchroniser, stable-time filter,
//                edge pulses and optional long-press pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int SYNC   = c_def_sync,
   parameter int STABLE = c_def_stable,
   parameter int HOLD   = c_def_hold
)(
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall,
   output logic hold
);

   localparam int                  c_cnt_w  = (clog2(STABLE + 1) < 1) ? 1 : clog2(STABLE + 1);
   localparam logic [c_cnt_w-1:0]  c_stable = c_cnt_w'(STABLE);

   logic [SYNC-1:0]    r_sync;
   logic               r_dr;
   logic [c_cnt_w-1:0] r_cnt;
   logic               w_s;
   logic               w_chg;

   assign w_s   = r_sync[SYNC-1];
   assign w_chg = w_s ^ r_dr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_dr   <= 1'b0;
         r_cnt  <= '0;
         q      <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC-2:0], d};
         r_dr   <= w_s;

         // Any movement of the synchronised input restarts the stable window.
         if (w_chg) begin
            r_cnt <= '0;
         end else if (r_cnt != c_stable) begin
            r_cnt <= r_cnt + 1'b1;
         end

         if (r_cnt == c_stable && r_dr != q) begin
            q    <= r_dr;
            rise <= r_dr;
            fall <= ~r_dr;
         end else begin
            rise <= 1'b0;
            fall <= 1'b0;
         end
      end
   end

   if (HOLD > 0) begin : g_hold
      localparam int                  c_hold_w  = (clog2(HOLD + 1) < 1) ? 1 : clog2(HOLD + 1);
      localparam logic [c_hold_w-1:0] c_hold    = c_hold_w'(HOLD);
      localparam logic [c_hold_w-1:0] c_hold_m1 = c_hold_w'(HOLD - 1);

      logic [c_hold_w-1:0] r_hcnt;

      // Counter saturates at HOLD so the pulse fires once per press.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_hcnt <= '0;
            hold   <= 1'b0;
         end else begin
            if (!q) begin
               r_hcnt <= '0;
            end else if (r_hcnt != c_hold) begin
               r_hcnt <= r_hcnt + 1'b1;
            end
            hold <= q && (r_hcnt == c_hold_m1);
         end
      end
   end else begin : g_no_hold
      assign hold = 1'b0;
   end

endmodule
`default_nettype wire

// File: rtl/debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bank
//  Description : CH independent switch debouncers with rise/fall/hold pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bank
   import debounce_pkg::*;
#(
   parameter int CH     = 4,
   parameter int SYNC   = c_def_sync,
   parameter int STABLE = c_def_stable,
   parameter int HOLD   = c_def_hold
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [CH-1:0] d,
   output logic [CH-1:0] q,
   output logic [CH-1:0] rise,
   output logic [CH-1:0] fall,
   output logic [CH-1:0] hold
);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      debounce_ch #(
         .SYNC   (SYNC),
         .STABLE (STABLE),
         .HOLD   (HOLD)
      ) u_ch (
         .clk  (clk),
         .rst  (rst),
         .d    (d[i]),
         .q    (q[i]),
         .rise (rise[i]),
         .fall (fall[i]),
         .hold (hold[i])
      );
   end

endmodule
`default_nettype wire

// File: tb/tb_debounce_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_bank
//  Description : Self-checking bench for debounce_bank (CH=4, SYNC=2,
//                STABLE=4, HOLD=10).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_debounce_bank;

   localparam int CH     = 4;
   localparam int SYNC   = 2;
   localparam int STABLE = 4;
   localparam int HOLD   = 10;
   localparam int LAT    = SYNC + STABLE + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [CH-1:0] d;
   logic [CH-1:0] q;
   logic [CH-1:0] rise;
   logic [CH-1:0] fall;
   logic [CH-1:0] hold;

   debounce_bank #(
      .CH     (CH),
      .SYNC   (SYNC),
      .STABLE (STABLE),
      .HOLD   (HOLD)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .d    (d),
      .q    (q),
      .rise (rise),
      .fall (fall),
      .hold (hold)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] dv;
      int         n;
      logic [3:0] q_end;
   } seg_t;

   typedef struct {
      int          edge_no;
      logic [15:0] outs;
   } exp_t;

   seg_t       tbl[$];
   exp_t       sb[$];
   logic [3:0] hist[$];
   logic [3:0] qm;
   int         rise_t[CH];
   int         t_edge;
   int         abs_edge;
   int         n_assert;
   int         n_fail;
   int         rise_cnt[CH];
   int         fall_cnt[CH];
   int         hold_cnt[CH];
   int         rise_at[CH];
   int         fall_at[CH];
   int         hold_at[CH];
   int         seg_start[32];
   logic [3:0] q_seen;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] samp(input int n);
      if (n <= 0 || n >= hist.size()) return 4'h0;
      return hist[n];
   endfunction

   task automatic model_reset();
      hist.delete();
      hist.push_back(4'h0);
      sb.delete();
      t_edge = 0;
      qm     = 4'h0;
      for (int c = 0; c < CH; c++) rise_t[c] = -1;
   endtask

   task automatic clear_events();
      q_seen = 4'h0;
      for (int c = 0; c < CH; c++) begin
         rise_cnt[c] = 0; fall_cnt[c] = 0; hold_cnt[c] = 0;
         rise_at[c] = -100; fall_at[c] = -100; hold_at[c] = -100;
      end
   endtask

   // Drive one input sample, predict the outputs after the next edge from the
   // sample history (q follows a value once STABLE+1 synchronised samples agree).
   task automatic step(input logic [3:0] dv);
      logic [3:0] nq, r, f, h, vref, cur;
      bit         same;
      exp_t       e;
      d = dv;
      t_edge++;
      abs_edge++;
      hist.push_back(dv);
      nq = qm; r = 4'h0; f = 4'h0; h = 4'h0;
      vref = samp(t_edge - SYNC - 1);
      for (int c = 0; c < CH; c++) begin
         same = 1'b1;
         for (int n = t_edge - LAT; n <= t_edge - SYNC - 1; n++) begin
            cur = samp(n);
            if (cur[c] != vref[c]) same = 1'b0;
         end
         if (same && vref[c] != qm[c]) begin
            nq[c] = vref[c];
            r[c]  = vref[c];
            f[c]  = ~vref[c];
            if (vref[c]) rise_t[c] = t_edge;
         end
         if (qm[c] && rise_t[c] >= 0 && (t_edge - rise_t[c]) == HOLD) h[c] = 1'b1;
         if (!nq[c]) rise_t[c] = -1;
      end
      qm = nq;
      e.edge_no = abs_edge;
      e.outs    = {nq, r, f, h};
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("edge %0d {q,rise,fall,hold}", e.edge_no), {16'h0, q, rise, fall, hold}, {16'h0, e.outs});
      q_seen |= q;
      for (int c = 0; c < CH; c++) begin
         if (rise[c]) begin rise_cnt[c]++; rise_at[c] = abs_edge; end
         if (fall[c]) begin fall_cnt[c]++; fall_at[c] = abs_edge; end
         if (hold[c]) begin hold_cnt[c]++; hold_at[c] = abs_edge; end
      end
   endtask

   // Assert reset between edges, hold across two edges, release after an edge.
   task automatic rst_pulse(input logic [3:0] dv);
      #2;
      rst = 1'b1;
      d   = dv;
      #1;
      chk("outputs immediately after reset assert", {16'h0, q, rise, fall, hold}, 32'h0);
      @(posedge clk);
      @(posedge clk);
      abs_edge += 2;
      #1;
      chk("outputs while reset held", {16'h0, q, rise, fall, hold}, 32'h0);
      rst = 1'b0;
      model_reset();
   endtask

   int rel;

   initial begin
      rst      = 1'b1;
      d        = 4'h0;
      n_assert = 0;
      n_fail   = 0;
      abs_edge = 0;
      model_reset();
      clear_events();
      rst_pulse(4'h0);

      // Clean press ch0, bounce ch1, glitch ch2, short press ch3 (ch0 held).
      tbl.push_back('{4'h0, 5, 4'h0});
      tbl.push_back('{4'h1, 30, 4'h1});
      for (int j = 0; j < 10; j++) tbl.push_back('{((j % 2) == 0) ? 4'h3 : 4'h1, 2, 4'h1});
      tbl.push_back('{4'h3, 20, 4'h3});
      tbl.push_back('{4'h7, 3, 4'h3});
      tbl.push_back('{4'h3, 15, 4'h3});
      tbl.push_back('{4'hB, 8, 4'hB});
      tbl.push_back('{4'h3, 15, 4'h3});

      clear_events();
      for (int i = 0; i < tbl.size(); i++) begin
         seg_start[i] = abs_edge + 1;
         for (int n = 0; n < tbl[i].n; n++) step(tbl[i].dv);
         chk($sformatf("segment %0d final q", i), {28'h0, q}, {28'h0, tbl[i].q_end});
      end

      chk("ch0 rise count",    rise_cnt[0], 1);
      chk("ch0 rise latency",  rise_at[0] - seg_start[1], LAT);
      chk("ch0 hold count",    hold_cnt[0], 1);
      chk("ch0 hold delay",    hold_at[0] - seg_start[1], LAT + HOLD);
      chk("ch0 fall count",    fall_cnt[0], 0);
      chk("ch1 rise count",    rise_cnt[1], 1);
      chk("ch1 rise latency",  rise_at[1] - seg_start[12], LAT);
      chk("ch1 fall count",    fall_cnt[1], 0);
      chk("ch2 event count",   rise_cnt[2] + fall_cnt[2] + hold_cnt[2], 0);
      chk("ch2 q never high",  {31'h0, q_seen[2]}, 0);
      chk("ch3 rise latency",  rise_at[3] - seg_start[15], LAT);
      chk("ch3 fall latency",  fall_at[3] - seg_start[16], LAT);
      chk("ch3 hold count",    hold_cnt[3], 0);

      // Input high through reset: rise on all channels after full latency.
      rst_pulse(4'hF);
      rel = abs_edge;
      clear_events();
      for (int n = 0; n < LAT + 3; n++) step(4'hF);
      for (int c = 0; c < CH; c++) begin
         chk($sformatf("ch%0d rise after reset release", c), rise_at[c] - (rel + 1), LAT);
         chk($sformatf("ch%0d rise count after release", c), rise_cnt[c], 1);
      end

      // Reset while ch0 is mid-count restarts the whole latency.
      for (int n = 0; n < 15; n++) step(4'h0);
      clear_events();
      for (int n = 0; n < SYNC + STABLE; n++) step(4'h1);
      chk("no pulse before mid-count reset", rise_cnt[0] + fall_cnt[0] + hold_cnt[0], 0);
      chk("q low before mid-count reset", {28'h0, q}, 32'h0);
      rst_pulse(4'h1);
      rel = abs_edge;
      for (int n = 0; n < LAT + 3; n++) step(4'h1);
      chk("ch0 rise count after mid-count reset", rise_cnt[0], 1);
      chk("ch0 restart latency", rise_at[0] - (rel + 1), LAT);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
